// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode constants, uop layout and the
// opcode-class table that tells which register fields an instruction uses.
package decode_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef logic [4:0] reg_addr_t;

    typedef struct packed {
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        reg_addr_t       rd;
        logic [6:0]      opcode;
        logic            illegal;
    } uop_t;

    typedef struct packed {
        logic use_rs1;
        logic use_rs2;
        logic use_rd;
    } src_use_t;

    function automatic src_use_t classify(input logic [6:0] opcode);
        src_use_t u;
        u = '0;
        case (opcode)
            OP_R:                       u = '{use_rs1: 1'b1, use_rs2: 1'b1, use_rd: 1'b1};
            OP_IMM, OP_LOAD, OP_JALR:   u = '{use_rs1: 1'b1, use_rs2: 1'b0, use_rd: 1'b1};
            OP_STORE, OP_BRANCH:        u = '{use_rs1: 1'b1, use_rs2: 1'b1, use_rd: 1'b0};
            OP_LUI, OP_AUIPC, OP_JAL:   u = '{use_rs1: 1'b0, use_rs2: 1'b0, use_rd: 1'b1};
            default:                    u = '0;
        endcase
        return u;
    endfunction

    function automatic logic is_known(input logic [6:0] opcode);
        case (opcode)
            OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_STORE,
            OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register marking an
// outstanding write, with two hazard lookups that see same-cycle writeback.
module reg_scoreboard
    import decode_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set_en,
    input  reg_addr_t       set_addr,
    input  logic            clr_en,
    input  reg_addr_t       clr_addr,
    input  logic            lk_a_en,
    input  reg_addr_t       lk_a_addr,
    output logic            lk_a_hazard,
    input  logic            lk_b_en,
    input  reg_addr_t       lk_b_addr,
    output logic            lk_b_hazard,
    output logic [NREG-1:0] busy
);

    logic [NREG-1:0] busy_next;

    // A writeback landing this cycle resolves the hazard immediately (bypass path).
    always_comb begin
        lk_a_hazard = lk_a_en && (lk_a_addr != '0) && busy[lk_a_addr]
                      && !(clr_en && (clr_addr == lk_a_addr));
        lk_b_hazard = lk_b_en && (lk_b_addr != '0) && busy[lk_b_addr]
                      && !(clr_en && (clr_addr == lk_b_addr));
    end

    // Clear applied first so a same-cycle set of the same register wins.
    always_comb begin
        busy_next = busy;
        if (clr_en)
            busy_next[clr_addr] = 1'b0;
        if (set_en && (set_addr != '0))
            busy_next[set_addr] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy <= '0;
        else
            busy <= busy_next;
    end

endmodule

// File: rtl/decode_operand_stage.sv
// Decode / operand-fetch stage: classifies the instruction, reads or bypasses
// source operands, stalls on busy sources and holds one uop for downstream.
module decode_operand_stage
    import decode_pkg::*;
#(
    parameter int XLEN = decode_pkg::XLEN,
    parameter int NREG = decode_pkg::NREG
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [4:0]      out_rd,
    output logic [6:0]      out_opcode,
    output logic            out_illegal,
    output logic [15:0]     stall_cnt
);

    src_use_t        use_c;
    reg_addr_t       rd_c;
    logic            use1;
    logic            use2;
    logic            haz_a;
    logic            haz_b;
    logic            hazard;
    logic            accept;
    logic            wr_rd;
    uop_t            uop_next;
    uop_t            uop_q;
    logic            valid_q;
    logic [NREG-1:0] sb_busy;
    logic            unused_bits;

    assign rs1   = in_instr[19:15];
    assign rs2   = in_instr[24:20];
    assign rd_c  = in_instr[11:7];
    assign use_c = classify(in_instr[6:0]);
    assign use1  = use_c.use_rs1 && (rs1 != '0);
    assign use2  = use_c.use_rs2 && (rs2 != '0);
    assign wr_rd = use_c.use_rd && (rd_c != '0);

    reg_scoreboard #(
        .NREG (NREG)
    ) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_en      (accept && wr_rd),
        .set_addr    (rd_c),
        .clr_en      (wb_valid),
        .clr_addr    (wb_rd),
        .lk_a_en     (use1),
        .lk_a_addr   (rs1),
        .lk_a_hazard (haz_a),
        .lk_b_en     (use2),
        .lk_b_addr   (rs2),
        .lk_b_hazard (haz_b),
        .busy        (sb_busy)
    );

    assign hazard   = haz_a || haz_b;
    assign in_ready = rst_n && (!valid_q || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    always_comb begin
        uop_next         = '0;
        uop_next.opcode  = in_instr[6:0];
        uop_next.illegal = !is_known(in_instr[6:0]);
        uop_next.rd      = use_c.use_rd ? rd_c : '0;
        if (use1)
            uop_next.op1 = (wb_valid && (wb_rd == rs1)) ? wb_data : rs1_data;
        if (use2)
            uop_next.op2 = (wb_valid && (wb_rd == rs2)) ? wb_data : rs2_data;
    end

    // Load on accept (also covers drain-and-refill in one cycle); otherwise hold fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            uop_q   <= '0;
        end else if (accept) begin
            valid_q <= 1'b1;
            uop_q   <= uop_next;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (in_valid && hazard && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end

    assign out_valid   = valid_q;
    assign out_op1     = uop_q.op1;
    assign out_op2     = uop_q.op2;
    assign out_rd      = uop_q.rd;
    assign out_opcode  = uop_q.opcode;
    assign out_illegal = uop_q.illegal;

    assign unused_bits = ^{in_instr[31:25], in_instr[14:12], sb_busy};

endmodule

// File: tb/tb_decode_operand_stage.sv
// Directed and randomized check of decode_operand_stage against a
// behavioural model of the issue, bypass and scoreboard rules.
module tb_decode_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [4:0]  rs1, rs2;
    logic [31:0] rs1_data, rs2_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_op1, out_op2;
    logic [4:0]  out_rd;
    logic [6:0]  out_opcode;
    logic        out_illegal;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    bit          m_valid;
    logic [31:0] m_op1, m_op2;
    logic [4:0]  m_rd;
    logic [6:0]  m_opc;
    bit          m_ill;
    bit [31:0]   m_busy;
    int          m_stall;

    logic [6:0]  op_pool [11];

    always #5 clk = ~clk;

    decode_operand_stage #(
        .XLEN (32),
        .NREG (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op1     (out_op1),
        .out_op2     (out_op2),
        .out_rd      (out_rd),
        .out_opcode  (out_opcode),
        .out_illegal (out_illegal),
        .stall_cnt   (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Which fields each RV32I opcode class reads / writes.
    function automatic void model_uses(input logic [6:0] op, output bit u1, output bit u2,
                                       output bit ud, output bit ill);
        u1 = 0; u2 = 0; ud = 0; ill = 0;
        case (op)
            7'h33:               begin u1 = 1; u2 = 1; ud = 1; end
            7'h13, 7'h03, 7'h67: begin u1 = 1; ud = 1; end
            7'h23, 7'h63:        begin u1 = 1; u2 = 1; end
            7'h37, 7'h17, 7'h6F: ud = 1;
            default:             ill = 1;
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"},   32'(out_valid),   32'(m_valid));
        chk({tag, ".out_op1"},     out_op1,          m_op1);
        chk({tag, ".out_op2"},     out_op2,          m_op2);
        chk({tag, ".out_rd"},      32'(out_rd),      32'(m_rd));
        chk({tag, ".out_opcode"},  32'(out_opcode),  32'(m_opc));
        chk({tag, ".out_illegal"}, 32'(out_illegal), 32'(m_ill));
        chk({tag, ".stall_cnt"},   32'(stall_cnt),   32'(m_stall));
    endtask

    task automatic model_clear();
        m_valid = 0; m_op1 = '0; m_op2 = '0; m_rd = '0; m_opc = '0; m_ill = 0;
        m_busy = '0; m_stall = 0;
    endtask

    // One clock: check combinational handshake, predict, clock, check registers.
    task automatic step(input string tag);
        bit u1, u2, ud, ill, s1, s2, hit1, hit2, haz, rdy, acc;
        logic [4:0] a1, a2, d;
        #1;
        a1 = in_instr[19:15];
        a2 = in_instr[24:20];
        d  = in_instr[11:7];
        model_uses(in_instr[6:0], u1, u2, ud, ill);
        s1   = u1 && (a1 != 0);
        s2   = u2 && (a2 != 0);
        hit1 = wb_valid && (wb_rd == a1);
        hit2 = wb_valid && (wb_rd == a2);
        haz  = (s1 && m_busy[a1] && !hit1) || (s2 && m_busy[a2] && !hit2);
        rdy  = rst_n && (!m_valid || out_ready) && !haz;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        chk({tag, ".rs1"}, 32'(rs1), 32'(a1));
        chk({tag, ".rs2"}, 32'(rs2), 32'(a2));
        acc = in_valid && rdy;
        if (in_valid && haz && m_stall < 65535) m_stall++;
        if (wb_valid) m_busy[wb_rd] = 0;
        if (acc && ud && d != 0) m_busy[d] = 1;
        if (acc) begin
            m_valid = 1;
            m_op1 = s1 ? (hit1 ? wb_data : rs1_data) : '0;
            m_op2 = s2 ? (hit2 ? wb_data : rs2_data) : '0;
            m_rd  = ud ? d : '0;
            m_opc = in_instr[6:0];
            m_ill = ill;
        end else if (out_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_clear();
        check_outputs({tag, ".async"});
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check_outputs({tag, ".held"});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w        = $urandom;
        w[6:0]   = op_pool[$urandom_range(0, 10)];
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    initial begin
        op_pool = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63,
                    7'h37, 7'h17, 7'h6F, 7'h7F, 7'h00};
        rst_n = 1'b0; in_valid = 0; in_instr = '0; rs1_data = '0; rs2_data = '0;
        wb_valid = 0; wb_rd = '0; wb_data = '0; out_ready = 1;
        model_clear();

        do_reset("rst0");

        in_valid = 1; in_instr = 32'h00700293; rs1_data = 32'hDEAD; rs2_data = 32'hBEEF;
        step("addi_x5");
        chk("addi_x5.rd_is_5", 32'(out_rd), 32'd5);
        chk("addi_x5.op1_zero", out_op1, 32'd0);

        in_instr = 32'h002081B3; rs1_data = 32'h11; rs2_data = 32'h22;
        step("add_x3");
        chk("add_x3.op1", out_op1, 32'h11);
        chk("add_x3.op2", out_op2, 32'h22);

        in_instr = 32'h00528333; rs1_data = 32'h1234; rs2_data = 32'h5678;
        repeat (3) step("raw_stall");
        chk("raw_stall.cnt3", 32'(stall_cnt), 32'd3);

        wb_valid = 1; wb_rd = 5'd5; wb_data = 32'd7;
        step("raw_bypass");
        chk("raw_bypass.op1", out_op1, 32'd7);
        chk("raw_bypass.op2", out_op2, 32'd7);
        wb_valid = 0;

        in_instr = 32'h002083B3; rs1_data = 32'hA1; rs2_data = 32'hA2; out_ready = 0;
        repeat (4) step("hold");
        out_ready = 1;
        step("release");
        in_instr = 32'h00208433; rs1_data = 32'hB1; rs2_data = 32'hB2;
        step("b2b");
        chk("b2b.rd8", 32'(out_rd), 32'd8);

        in_instr = 32'hFFFFFFFF;
        step("illegal");
        chk("illegal.flag", 32'(out_illegal), 32'd1);
        in_instr = 32'h000F8433; rs1_data = 32'hC1;
        step("x31_not_busy");

        in_instr = 32'h00700293;
        step("addi_x5_again");
        in_instr = 32'h00528333;
        repeat (2) step("stall_pre_rst");
        do_reset("rst_mid_stall");
        rs1_data = 32'hD1; rs2_data = 32'hD2;
        step("post_rst_x5");
        wb_valid = 1; wb_rd = 5'd5; wb_data = 32'hEE; in_valid = 0;
        step("stale_wb");
        wb_valid = 0;

        repeat (400) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            rs1_data  = $urandom;
            rs2_data  = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            wb_valid  = ($urandom_range(0, 2) == 0);
            wb_rd     = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
